// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, issues requests to a variable-latency imem,
// buffers returned words in order and drives the IF/ID register under stall/flush/redirect.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned DW = CW + 4;

    logic [XLEN-1:0]   pcF;
    logic [XLEN-1:0]   entPc    [QDEPTH];
    logic [31:0]       entInstr [QDEPTH];
    logic [QDEPTH-1:0] entFilled;
    logic [PW-1:0]     allocPtr;
    logic [PW-1:0]     fillPtr;
    logic [PW-1:0]     headPtr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pendCnt;
    logic [DW-1:0]     discard;
    logic [DW-1:0]     discardRedir;

    logic reqFire;
    logic rspTake;
    logic rspDrop;
    logic headReady;
    logic popHead;

    assign imem_req_valid = !StallF && !PCSrcE && (count < CW'(QDEPTH));
    assign imem_req_addr  = pcF;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign rspTake        = imem_rsp_valid && (discard == '0) && !PCSrcE;
    assign rspDrop        = imem_rsp_valid && (discard != '0);
    assign headReady      = entFilled[headPtr];
    assign popHead        = !FlushD && !PCSrcE && !StallD && headReady;

    // Outstanding stale words on redirect; a word arriving in the redirect cycle is one of them.
    always_comb begin
        discardRedir = discard + DW'(pendCnt);
        if (imem_rsp_valid && (discardRedir != '0))
            discardRedir = discardRedir - DW'(1);
    end

    // Payload storage needs no reset: entFilled alone decides what is live.
    always_ff @(posedge clk) begin
        if (reqFire)
            entPc[allocPtr] <= pcF;
        if (rspTake)
            entInstr[fillPtr] <= imem_rsp_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcF       <= RESET_PC;
            entFilled <= '0;
            allocPtr  <= '0;
            fillPtr   <= '0;
            headPtr   <= '0;
            count     <= '0;
            pendCnt   <= '0;
            discard   <= '0;
            ValidD    <= 1'b0;
            InstrD    <= NOP;
            PCD       <= '0;
            PCPlus4D  <= '0;
        end else begin
            if (FlushD || PCSrcE) begin
                ValidD <= 1'b0;
                InstrD <= NOP;
            end else if (!StallD) begin
                if (headReady) begin
                    ValidD   <= 1'b1;
                    InstrD   <= entInstr[headPtr];
                    PCD      <= entPc[headPtr];
                    PCPlus4D <= entPc[headPtr] + XLEN'(4);
                end else begin
                    ValidD <= 1'b0;
                    InstrD <= NOP;
                end
            end

            if (PCSrcE) begin
                pcF       <= PCTargetE;
                entFilled <= '0;
                allocPtr  <= '0;
                fillPtr   <= '0;
                headPtr   <= '0;
                count     <= '0;
                pendCnt   <= '0;
                discard   <= discardRedir;
            end else begin
                if (reqFire) begin
                    allocPtr <= allocPtr + PW'(1);
                    pcF      <= pcF + XLEN'(4);
                end
                if (popHead) begin
                    entFilled[headPtr] <= 1'b0;
                    headPtr            <= headPtr + PW'(1);
                end
                if (rspTake) begin
                    entFilled[fillPtr] <= 1'b1;
                    fillPtr            <= fillPtr + PW'(1);
                end else if (rspDrop) begin
                    discard <= discard - DW'(1);
                end
                count   <= count + CW'(reqFire) - CW'(popHead);
                pendCnt <= pendCnt + CW'(reqFire) - CW'(rspTake);
            end
        end
    end

endmodule
